multi_pulse_generator: RTL

Parametrised, multi-channel successor to the single-channel pulse generator. A single shared sequencer runs repeated DELAY/PULSE frames. Each channel drives its own output, gated by a per-channel enable and start offset inside the pulse window. Adds a graceful stop command, a done strobe and a repetition status counter. Sits between the HPS-side configuration registers and the board pins/LEDs.

---
 rtl/multi_pulse_generator_if.sv | 43 ++++
 rtl/multi_pulse_generator.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multi_pulse_generator_if.sv
// Configuration and status bundle between the HPS register block and multi_pulse_generator.
// MULTI_PULSE_GEN_POLARITY_EN adds the per-channel ch_polarity input.
interface multi_pulse_generator_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int REP_W  = 16
);
    logic                    start_in;
    logic                    stop_in;
    logic [CNT_W-1:0]        delay_cycles;
    logic [CNT_W-1:0]        pulse_width_cycles;
    logic [REP_W-1:0]        repetition;
    logic [NUM_CH-1:0]       ch_enable;
    logic [NUM_CH*CNT_W-1:0] ch_offset;
`ifdef MULTI_PULSE_GEN_POLARITY_EN
    logic [NUM_CH-1:0]       ch_polarity;
`endif
    logic                    start_ack;
    logic                    busy;
    logic                    done;
    logic [REP_W-1:0]        rep_count;
    logic [NUM_CH-1:0]       pulse_out;
    logic                    pulse_led;
    logic                    delay_led;

    modport master (
`ifdef MULTI_PULSE_GEN_POLARITY_EN
        output ch_polarity,
`endif
        output start_in, stop_in, delay_cycles, pulse_width_cycles, repetition,
        output ch_enable, ch_offset,
        input  start_ack, busy, done, rep_count, pulse_out, pulse_led, delay_led
    );

    modport slave (
`ifdef MULTI_PULSE_GEN_POLARITY_EN
        input  ch_polarity,
`endif
        input  start_in, stop_in, delay_cycles, pulse_width_cycles, repetition,
        input  ch_enable, ch_offset,
        output start_ack, busy, done, rep_count, pulse_out, pulse_led, delay_led
    );
endinterface

// File: rtl/multi_pulse_generator.sv
// Multi-channel DELAY/PULSE frame sequencer with per-channel enable/offset, graceful stop and done strobe.
// Optional MULTI_PULSE_GEN_POLARITY_EN: per-channel output polarity latched at start.
//
// state   | meaning
// IDLE    | waiting for an armed start; counters held at 0
// DELAY   | counting down the inter-frame delay; delay_led high
// PULSE   | phase counter runs 0..W-1; channels rise at their offsets
module multi_pulse_generator #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int REP_W  = 16
) (
    input logic                    clk,
    input logic                    reset_n,
    multi_pulse_generator_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;

    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_armed;
    logic                    r_stop_pend;
    logic [CNT_W-1:0]        r_delay;
    logic [CNT_W-1:0]        r_width;
    logic [REP_W-1:0]        r_rep;
    logic [NUM_CH-1:0]       r_en;
    logic [NUM_CH*CNT_W-1:0] r_off;
    logic [NUM_CH-1:0]       r_pol;

    logic                    r_start_ack;
    logic                    r_busy;
    logic                    r_done;
    logic [REP_W-1:0]        r_rep_count;
    logic [NUM_CH-1:0]       r_pulse_out;
    logic                    r_pulse_led;
    logic                    r_delay_led;

    logic                    w_accept;
    logic [1:0]              w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_done_nxt;
    logic                    w_stop_pend_nxt;
    logic [REP_W-1:0]        w_rep_count_nxt;
    logic [REP_W-1:0]        w_rep_inc;
    logic [REP_W:0]          w_rep_plus1;
    logic                    w_last_rep;
    logic [CNT_W-1:0]        w_delay_l;
    logic [CNT_W-1:0]        w_width_l;
    logic [REP_W-1:0]        w_rep_l;
    logic [NUM_CH-1:0]       w_en_l;
    logic [NUM_CH*CNT_W-1:0] w_off_l;
    logic [NUM_CH-1:0]       w_pol_l;
    logic [NUM_CH-1:0]       w_active_nxt;

    // Configuration is taken from the inputs on the accept edge so a zero delay can pulse immediately.
    always_comb begin
        w_accept  = (r_state == S_IDLE) && r_armed && bus.start_in && !bus.stop_in;
        w_delay_l = w_accept ? bus.delay_cycles       : r_delay;
        w_width_l = w_accept ? bus.pulse_width_cycles : r_width;
        w_rep_l   = w_accept ? bus.repetition         : r_rep;
        w_en_l    = w_accept ? bus.ch_enable          : r_en;
        w_off_l   = w_accept ? bus.ch_offset          : r_off;
`ifdef MULTI_PULSE_GEN_POLARITY_EN
        w_pol_l   = w_accept ? bus.ch_polarity        : r_pol;
`else
        w_pol_l   = '0;
`endif
    end

    always_comb begin
        w_rep_plus1 = {1'b0, r_rep_count} + {{REP_W{1'b0}}, 1'b1};
        w_rep_inc   = (&r_rep_count) ? r_rep_count : w_rep_plus1[REP_W-1:0];
        w_last_rep  = (r_rep != '0) && (w_rep_plus1 == {1'b0, r_rep});
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_done_nxt      = 1'b0;
        w_stop_pend_nxt = r_stop_pend;
        w_rep_count_nxt = r_rep_count;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt       = '0;
                w_stop_pend_nxt = 1'b0;
                if (w_accept) begin
                    w_rep_count_nxt = '0;
                    // A zero-width sequence spends exactly one busy cycle before done.
                    if (bus.pulse_width_cycles == '0) begin
                        w_state_nxt = S_DELAY;
                    end else if (bus.delay_cycles != '0) begin
                        w_state_nxt = S_DELAY;
                        w_cnt_nxt   = bus.delay_cycles - CNT_W'(1);
                    end else begin
                        w_state_nxt = S_PULSE;
                    end
                end
            end
            S_DELAY: begin
                if (bus.stop_in || (r_cnt == '0 && r_width == '0)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_PULSE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_PULSE: begin
                w_stop_pend_nxt = r_stop_pend | bus.stop_in;
                if (r_cnt == r_width - CNT_W'(1)) begin
                    w_rep_count_nxt = w_rep_inc;
                    if (w_last_rep || w_stop_pend_nxt) begin
                        w_state_nxt     = S_IDLE;
                        w_cnt_nxt       = '0;
                        w_done_nxt      = 1'b1;
                        w_stop_pend_nxt = 1'b0;
                    end else if (r_delay != '0) begin
                        w_state_nxt = S_DELAY;
                        w_cnt_nxt   = r_delay - CNT_W'(1);
                    end else begin
                        w_state_nxt = S_PULSE;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_active_nxt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_active_nxt[k] = (w_state_nxt == S_PULSE) && w_en_l[k] &&
                              (w_cnt_nxt >= w_off_l[k*CNT_W +: CNT_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_armed     <= 1'b0;
            r_stop_pend <= 1'b0;
            r_delay     <= '0;
            r_width     <= '0;
            r_rep       <= '0;
            r_en        <= '0;
            r_off       <= '0;
            r_pol       <= '0;
            r_start_ack <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rep_count <= '0;
            r_pulse_out <= '0;
            r_pulse_led <= 1'b0;
            r_delay_led <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_stop_pend <= w_stop_pend_nxt;
            if (!bus.start_in) begin
                r_armed <= 1'b1;
            end else if (w_accept) begin
                r_armed <= 1'b0;
            end
            r_delay     <= w_delay_l;
            r_width     <= w_width_l;
            r_rep       <= w_rep_l;
            r_en        <= w_en_l;
            r_off       <= w_off_l;
            r_pol       <= w_pol_l;
            r_start_ack <= w_accept;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= w_done_nxt;
            r_rep_count <= w_rep_count_nxt;
            r_pulse_out <= w_active_nxt ^ w_pol_l;
            r_pulse_led <= |w_active_nxt;
            r_delay_led <= (w_state_nxt == S_DELAY);
        end
    end

    assign bus.start_ack = r_start_ack;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.rep_count = r_rep_count;
    assign bus.pulse_out = r_pulse_out;
    assign bus.pulse_led = r_pulse_led;
    assign bus.delay_led = r_delay_led;
endmodule
